// File: rtl/intr_handler_pkg.sv
// Shared types for the multi-channel interrupt handler: FSM states,
// service phase codes and the Moore output decodes derived from the state.
package intr_handler_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_ENIN,
        S_ENIN_W,
        S_INTR,
        S_INTR_1,
        S_INTR_W
    } state_t;

    localparam logic [1:0] USC_IDLE = 2'b00;
    localparam logic [1:0] USC_RUN  = 2'b01;
    localparam logic [1:0] USC_DONE = 2'b10;
    localparam logic [1:0] USC_WAIT = 2'b11;

    function automatic logic [1:0] uscite_of(input state_t s);
        case (s)
            S_INTR:   return USC_RUN;
            S_INTR_1: return USC_DONE;
            S_INTR_W: return USC_WAIT;
            default:  return USC_IDLE;
        endcase
    endfunction

    function automatic logic busy_of(input state_t s);
        return !((s == S_INIT) || (s == S_WAIT));
    endfunction

endpackage

// File: rtl/intr_handler_n_rr_arbiter.sv
// Combinational round-robin search: first set request bit found walking
// upward from (last_i + 1), wrapping modulo CHANNELS.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]    last_i,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        // Offset 1 is the channel after the previous winner; offset CHANNELS wraps back to it.
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = IDX_W'((int'(last_i) + i) % CHANNELS);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                grant_idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/intr_handler_n.sv
// Multi-channel interrupt handler: round-robin grant, ack/service/release
// handshake against cont_eql, and sticky masking of channels that time out.
module intr_handler_n
    import intr_handler_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  CNT_W    = 8,
    parameter int  TIMEOUT  = 16,
    localparam int IDX_W    = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] eql,
    input  logic                cont_eql,
    input  logic [CHANNELS-1:0] err_clr,
    output logic [IDX_W-1:0]    cc_mux,
    output logic [1:0]          uscite,
    output logic                enable_count,
    output logic                ackout,
    output logic                busy,
    output logic [CHANNELS-1:0] err_flag
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RESET   = IDX_W'(CHANNELS - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] err_q, err_d;

    logic                ackout_q, enable_q, busy_q;
    logic [1:0]          uscite_q;

    logic [IDX_W-1:0]    arb_grant;
    logic                arb_any;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req_i       (eql & ~err_q),
        .last_i      (last_q),
        .grant_idx_o (arb_grant),
        .any_o       (arb_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        // Clears are applied first so a timeout set on the same bit overrides them.
        err_d   = err_q & ~err_clr;

        case (state_q)
            S_INIT: state_d = S_WAIT;
            S_WAIT: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    cnt_d   = '0;
                    state_d = S_ENIN;
                end
            end
            S_ENIN: state_d = S_ENIN_W;
            S_ENIN_W: begin
                cnt_d = cnt_q + 1'b1;
                if (!eql[grant_q]) begin
                    state_d = S_INTR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d[grant_q] = 1'b1;
                    last_d         = grant_q;
                    state_d        = S_INTR_W;
                end
            end
            S_INTR: begin
                if (cont_eql) state_d = S_INTR_1;
            end
            S_INTR_1: begin
                last_d  = grant_q;
                state_d = S_INTR_W;
            end
            S_INTR_W: begin
                if (!cont_eql) state_d = S_WAIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_INIT;
            grant_q  <= '0;
            last_q   <= LAST_RESET;
            cnt_q    <= '0;
            err_q    <= '0;
            ackout_q <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            uscite_q <= USC_IDLE;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ackout_q <= (state_d == S_ENIN);
            enable_q <= (state_d == S_ENIN_W);
            busy_q   <= busy_of(state_d);
            uscite_q <= uscite_of(state_d);
        end
    end

    assign cc_mux       = grant_q;
    assign uscite       = uscite_q;
    assign enable_count = enable_q;
    assign ackout       = ackout_q;
    assign busy         = busy_q;
    assign err_flag     = err_q;

endmodule

// File: tb/tb_intr_handler_n.sv
// Directed bench for intr_handler_n with a phase-level reference model that
// is compared against every output on each falling clock edge.
module tb_intr_handler_n;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    localparam int P_INIT = 0;
    localparam int P_IDLE = 1;
    localparam int P_ACK  = 2;
    localparam int P_HOLD = 3;
    localparam int P_SERV = 4;
    localparam int P_DONE = 5;
    localparam int P_REL  = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] eql = '0;
    logic          contEql = 1'b0;
    logic [CH-1:0] errClr = '0;
    logic [IW-1:0] ccMux;
    logic [1:0]    uscite;
    logic          enableCount;
    logic          ackout;
    logic          busy;
    logic [CH-1:0] errFlag;

    int total = 0;
    int bad   = 0;

    int            mPhase = P_INIT;
    int            mGrant = 0;
    int            mLast  = CH - 1;
    int            mCnt   = 0;
    logic [CH-1:0] mErr   = '0;
    bit            mdlOn  = 1'b0;

    intr_handler_n #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .TIMEOUT  (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .eql          (eql),
        .cont_eql     (contEql),
        .err_clr      (errClr),
        .cc_mux       (ccMux),
        .uscite       (uscite),
        .enable_count (enableCount),
        .ackout       (ackout),
        .busy         (busy),
        .err_flag     (errFlag)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mStep();
        logic [CH-1:0] nErr;
        nErr = mErr & ~errClr;
        case (mPhase)
            P_INIT: mPhase = P_IDLE;
            P_IDLE: begin
                for (int j = 1; j <= CH; j++) begin
                    int k;
                    k = (mLast + j) % CH;
                    if (mPhase == P_IDLE && eql[k] && !mErr[k]) begin
                        mGrant = k;
                        mCnt   = 0;
                        mPhase = P_ACK;
                    end
                end
            end
            P_ACK: mPhase = P_HOLD;
            P_HOLD: begin
                mCnt++;
                if (!eql[mGrant]) begin
                    mPhase = P_SERV;
                end else if (mCnt == TO) begin
                    nErr[mGrant] = 1'b1;
                    mLast        = mGrant;
                    mPhase       = P_REL;
                end
            end
            P_SERV: if (contEql) mPhase = P_DONE;
            P_DONE: begin
                mLast  = mGrant;
                mPhase = P_REL;
            end
            P_REL: if (!contEql) mPhase = P_IDLE;
            default: mPhase = P_INIT;
        endcase
        mErr = nErr;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mPhase = P_INIT;
            mGrant = 0;
            mLast  = CH - 1;
            mCnt   = 0;
            mErr   = '0;
            mdlOn  = 1'b1;
        end else if (mdlOn) begin
            mStep();
        end
    end

    always @(negedge clock) begin
        if (mdlOn) begin
            int expUsc;
            case (mPhase)
                P_SERV:  expUsc = 1;
                P_DONE:  expUsc = 2;
                P_REL:   expUsc = 3;
                default: expUsc = 0;
            endcase
            checkOutput("cc_mux", int'(ccMux), mGrant);
            checkOutput("uscite", int'(uscite), expUsc);
            checkOutput("enable_count", int'(enableCount), int'(mPhase == P_HOLD));
            checkOutput("ackout", int'(ackout), int'(mPhase == P_ACK));
            checkOutput("busy", int'(busy), int'(mPhase >= P_ACK));
            checkOutput("err_flag", int'(errFlag), int'(mErr));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [CH-1:0] e, input logic c, input logic [CH-1:0] clr);
        eql     = e;
        contEql = c;
        errClr  = clr;
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, '0);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic waitAck(input int budget);
        int n;
        n = 0;
        while (!ackout && n < budget) begin
            cyc();
            n++;
        end
        checkOutput("ackSeen", int'(ackout), 1);
    endtask

    task automatic serviceOne(output int g);
        waitAck(8);
        g = int'(ccMux);
        cyc();
        eql[g[IW-1:0]] = 1'b0;
        cyc();
        contEql = 1'b1;
        cyc();
        contEql = 1'b0;
        cyc();
        eql[g[IW-1:0]] = 1'b1;
        cyc();
    endtask

    initial begin
        int g;
        int n;
        int acks;
        int rrExp[5];
        rrExp = '{0, 1, 2, 3, 0};

        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstCcMux", int'(ccMux), 0);
        checkOutput("rstUscite", int'(uscite), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstAck", int'(ackout), 0);
        checkOutput("rstErr", int'(errFlag), 0);
        cyc();
        cyc();
        reset = 1'b0;

        repeat (20) cyc();
        checkOutput("idleBusy", int'(busy), 0);
        checkOutput("idleUscite", int'(uscite), 0);
        checkOutput("idleAck", int'(ackout), 0);

        applyStimulus(4'b0001, 1'b0, '0);
        waitAck(4);
        checkOutput("svcGrant", int'(ccMux), 0);
        checkOutput("svcBusyAck", int'(busy), 1);
        cyc();
        checkOutput("svcAckGone", int'(ackout), 0);
        checkOutput("svcEnable", int'(enableCount), 1);
        applyStimulus('0, 1'b0, '0);
        cyc();
        checkOutput("svcUscRun", int'(uscite), 1);
        applyStimulus('0, 1'b1, '0);
        cyc();
        checkOutput("svcUscDone", int'(uscite), 2);
        applyStimulus('0, 1'b0, '0);
        cyc();
        checkOutput("svcUscWait", int'(uscite), 3);
        cyc();
        checkOutput("svcUscIdle", int'(uscite), 0);
        checkOutput("svcBusyEnd", int'(busy), 0);

        doReset();
        applyStimulus(4'b1111, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            serviceOne(g);
            checkOutput($sformatf("rrGrant%0d", k), g, rrExp[k]);
        end

        doReset();
        applyStimulus(4'b0100, 1'b0, '0);
        waitAck(8);
        checkOutput("toGrant", int'(ccMux), 2);
        cyc();
        n = 0;
        while (enableCount && n < 40) begin
            n++;
            cyc();
        end
        checkOutput("toEnCycles", n, 16);
        checkOutput("toFlag", int'(errFlag), 4);
        checkOutput("toUscWait", int'(uscite), 3);
        cyc();
        acks = 0;
        repeat (8) begin
            cyc();
            if (ackout) acks++;
        end
        checkOutput("toSkip", acks, 0);
        checkOutput("toIdleBusy", int'(busy), 0);
        applyStimulus(4'b0100, 1'b0, 4'b0100);
        cyc();
        errClr = '0;
        checkOutput("clrFlag", int'(errFlag), 0);
        waitAck(4);
        checkOutput("clrGrant", int'(ccMux), 2);

        cyc();
        applyStimulus('0, 1'b0, '0);
        cyc();
        checkOutput("preRstUsc", int'(uscite), 1);
        contEql = 1'b1;
        reset   = 1'b1;
        #1;
        checkOutput("midRstUsc", int'(uscite), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstCcMux", int'(ccMux), 0);
        checkOutput("midRstErr", int'(errFlag), 0);
        cyc();
        reset = 1'b0;
        applyStimulus(4'b1111, 1'b0, '0);
        waitAck(8);
        checkOutput("postRstGrant", int'(ccMux), 0);

        doReset();
        applyStimulus(4'b0001, 1'b0, '0);
        waitAck(8);
        cyc();
        repeat (15) cyc();
        checkOutput("lastHoldCycle", int'(enableCount), 1);
        errClr = 4'b0001;
        cyc();
        errClr = '0;
        checkOutput("setWins", int'(errFlag[0]), 1);
        checkOutput("setWinsUsc", int'(uscite), 3);
        applyStimulus('0, 1'b0, '0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
